decode_split_stage: RTL
=======================

Name: decode_split_stage

Overview:
- Parametrised, registered successor to the single-format field splitters. Splits a bundle of WIDTH RV32/RV64 instructions into opcode, rd, rs1, rs2, func3, func7 and a sign-extended immediate for all base formats (R/I/S/B/U/J).
- Also reports the detected format and an illegal-opcode flag per lane.
- Sits between fetch and rename/dispatch, with a valid/ready handshake, a 2-entry skid buffer and a flush input.

Parameters:
- WIDTH, 2, instructions (lanes) per bundle, 1..4.
- XLEN, 32, immediate output width, 32 or 64.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  drop all buffered bundles
- in_valid  in  1  input bundle valid
- in_ready  out  1  stage can accept a bundle
- in_lane_valid  in  WIDTH  per-lane valid within the bundle
- in_instr  in  WIDTH*32  lane i at [32i+31:32i]
- out_valid  out  1  output bundle valid
- out_ready  in  1  downstream accepts
- out_lane_valid  out  WIDTH  registered copy of in_lane_valid
- out_opcode  out  WIDTH*7  per-lane opcode
- out_rd, out_rs1, out_rs2  out  WIDTH*5 each  per-lane register fields
- out_func3  out  WIDTH*3  per-lane func3
- out_func7  out  WIDTH*7  per-lane func7
- out_imm  out  WIDTH*XLEN  per-lane sign-extended immediate
- out_fmt  out  WIDTH*3  per-lane format code
- out_illegal  out  WIDTH  per-lane unrecognised opcode

Behaviour:
- Reset and interface:
  - One clock; reset is asynchronous and active-high.
  - While rst is high, every output is 0, including in_ready.
  - in_ready = !skid_valid && !rst, so it is 1 from the first cycle after reset release.
- Format decode:
  - R: 0110011 → fmt 0
  - I: 0010011, 0000011, 1100111, 1110011 → fmt 1
  - S: 0100011 → fmt 2
  - B: 1100011 → fmt 3
  - U: 0110111, 0010111 → fmt 4
  - J: 1101111 → fmt 5
  - Any other opcode → fmt 7, illegal=1, imm=0.
- Immediates, each sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R: imm=0.
- Raw fields: opcode, rd, rs1, rs2, func3 and func7 are always passed raw from fixed bit positions, regardless of format.
- Inactive lanes: a lane with lane_valid=0 outputs all fields 0, fmt 0 and illegal 0.
- Latency: 1 cycle from acceptance (in_valid && in_ready) to out_valid when the output register is free.
- Transfers:
  - A bundle is accepted when in_valid && in_ready.
  - It is consumed when out_valid && out_ready.
  - The bundle is atomic: lanes never split across transfers.
- Buffer moves on each clock:
  - Output register empty, or being consumed, while skid is empty → an accepted bundle loads the output register.
  - Output register holds and is not consumed → an accepted bundle loads skid.
  - Output register is consumed while skid is valid → skid moves to the output register and skid empties.
- Ordering: bundles leave in acceptance order, with none lost or duplicated.
- Stability: output data holds stable while out_valid && !out_ready.
- Flush:
  - On the next edge, out_valid=0 and skid_valid=0.
  - A bundle offered in the same cycle as flush is dropped.
  - Flush dominates accept and consume.
- Reset mid-operation clears both entries immediately; no partial bundle emerges.

Decomposition:
- decode_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL)
  - the fmt_e enum {FMT_R=0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD=7}
  - a packed per-lane field struct.
- Sub-module rv_field_extract: combinational, one lane, parametrised by XLEN, instantiated WIDTH times. The top module holds only the handshake and skid registers.

Test Plan:
1. Single instructions, out_ready=1, lane 0 only:
   - 0xFE000EE3 → fmt 3, rs1=0, rs2=0, imm=0xFFFFFFFC, out_valid exactly 1 cycle after accept.
   - 0xFFF10093 → fmt 1, rd=1, rs1=2, imm=0xFFFFFFFF.
2. Two-lane bundle:
   - lane 0: 0x123452B7 → fmt 4, rd=5, imm=0x12345000.
   - lane 1: 0x001000EF → fmt 5, rd=1, imm=0x00000800.
   - XLEN=64 build: same immediates, with upper 32 bits following the sign.
3. Illegal opcode and inactive lane:
   - 0x0000007F → illegal=1, fmt 7, imm=0.
   - in_lane_valid=2'b01 → lane 1 all-zero.
4. Backpressure:
   - Hold out_ready=0, offer bundles A, B, C back-to-back → A and B accepted, in_ready=0 from the cycle after B.
   - C is held with no acceptance.
   - Raise out_ready → A, B, C emerge in order on consecutive cycles, with no gaps after the first.
5. Flush and buffer state:
   - With both entries full, assert flush while in_valid=1 → next cycle out_valid=0 and in_ready=1.
   - The flushed bundles and the bundle offered during flush never appear at the output.
6. Reset mid-stream:
   - Assert rst asynchronously between edges while out_valid=1 → out_valid, in_ready and all fields go to 0 immediately.
   - After release, the first new bundle passes with 1-cycle latency.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decode/split stage.
//   - RV32/RV64 base opcodes used for format detection
//   - fmt_e: per-lane instruction format code reported downstream
//   - lane_fields_t: raw register/function fields plus format and illegal flag
//   - fmt_of(): maps an opcode to its base format (FMT_BAD if unrecognised)
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_BAD = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] func3;
    logic [6:0] func7;
    fmt_e       fmt;
    logic       illegal;
  } lane_fields_t;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_R:                                   f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:    f = FMT_I;
      OP_STORE:                               f = FMT_S;
      OP_BRANCH:                              f = FMT_B;
      OP_LUI, OP_AUIPC:                       f = FMT_U;
      OP_JAL:                                 f = FMT_J;
      default:                                f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv_field_extract.sv
// Combinational field splitter for a single instruction lane.
// Ports:
//   lane_valid  in   lane carries a real instruction; when 0 every output is 0
//   instr       in   32-bit instruction word
//   fields      out  raw opcode/rd/rs1/rs2/func3/func7, detected format, illegal flag
//   imm         out  format-specific immediate, sign-extended from instr[31] to XLEN
module rv_field_extract
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             lane_valid,
  input  logic [31:0]      instr,
  output lane_fields_t     fields,
  output logic [XLEN-1:0]  imm
);

  fmt_e               fmt;
  logic signed [31:0] imm32;

  assign fmt = fmt_of(instr[6:0]);

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    fields = '0;
    imm    = '0;
    if (lane_valid) begin
      fields.opcode  = instr[6:0];
      fields.rd      = instr[11:7];
      fields.func3   = instr[14:12];
      fields.rs1     = instr[19:15];
      fields.rs2     = instr[24:20];
      fields.func7   = instr[31:25];
      fields.fmt     = fmt;
      fields.illegal = (fmt == FMT_BAD);
      // Width cast of a signed operand sign-extends for XLEN=64.
      imm            = XLEN'(imm32);
    end
  end

endmodule

// File: rtl/decode_split_stage.sv
// Registered decode/split stage between fetch and rename/dispatch.
// Each bundle of WIDTH instructions is split per lane into raw fields, format,
// illegal flag and sign-extended immediate, then held in a 2-entry buffer
// (output register + skid register) behind a valid/ready handshake.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               drop every buffered bundle and any bundle offered this cycle
//   in_valid/in_ready   upstream handshake; in_lane_valid/in_instr carry the bundle
//   out_valid/out_ready downstream handshake
//   out_*               per-lane decoded fields, lane i in slice i of each bus
//
// Buffer occupancy:
//   out_v skid_v | meaning
//   0     0      | empty, accepted bundle goes straight to the output register
//   1     0      | one bundle presented; accept lands in skid unless consumed
//   1     1      | full, in_ready low; consume moves skid to the output register
module decode_split_stage
  import decode_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_lane_valid,
  input  logic [WIDTH*32-1:0]   in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_lane_valid,
  output logic [WIDTH*7-1:0]    out_opcode,
  output logic [WIDTH*5-1:0]    out_rd,
  output logic [WIDTH*5-1:0]    out_rs1,
  output logic [WIDTH*5-1:0]    out_rs2,
  output logic [WIDTH*3-1:0]    out_func3,
  output logic [WIDTH*7-1:0]    out_func7,
  output logic [WIDTH*XLEN-1:0] out_imm,
  output logic [WIDTH*3-1:0]    out_fmt,
  output logic [WIDTH-1:0]      out_illegal
);

  localparam int FW = $bits(lane_fields_t);
  localparam int LW = FW + XLEN;

  logic [WIDTH-1:0][LW-1:0] dec_b;
  logic [WIDTH-1:0][LW-1:0] out_b;
  logic [WIDTH-1:0][LW-1:0] skid_b;
  logic [WIDTH-1:0]         out_lv;
  logic [WIDTH-1:0]         skid_lv;
  logic                     out_v;
  logic                     skid_v;
  logic                     accept;

  assign in_ready = !skid_v && !rst;
  assign accept   = in_valid && in_ready;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    lane_fields_t     dec_f;
    logic [XLEN-1:0]  dec_imm;
    lane_fields_t     o_f;

    rv_field_extract #(.XLEN(XLEN)) u_extract (
      .lane_valid (in_lane_valid[g]),
      .instr      (in_instr[32*g +: 32]),
      .fields     (dec_f),
      .imm        (dec_imm)
    );

    assign dec_b[g] = {dec_imm, dec_f};
    assign o_f      = out_b[g][FW-1:0];

    assign out_opcode[7*g +: 7]     = o_f.opcode;
    assign out_rd[5*g +: 5]         = o_f.rd;
    assign out_rs1[5*g +: 5]        = o_f.rs1;
    assign out_rs2[5*g +: 5]        = o_f.rs2;
    assign out_func3[3*g +: 3]      = o_f.func3;
    assign out_func7[7*g +: 7]      = o_f.func7;
    assign out_fmt[3*g +: 3]        = o_f.fmt;
    assign out_illegal[g]           = o_f.illegal;
    assign out_imm[XLEN*g +: XLEN]  = out_b[g][LW-1:FW];
  end

  assign out_valid      = out_v;
  assign out_lane_valid = out_lv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v   <= 1'b0;
      skid_v  <= 1'b0;
      out_lv  <= '0;
      skid_lv <= '0;
      out_b   <= '0;
      skid_b  <= '0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      // Skid only fills while the output register is occupied, so out_v is 1 here.
      if (out_ready) begin
        out_b   <= skid_b;
        out_lv  <= skid_lv;
        skid_v  <= 1'b0;
      end
    end else if (!out_v || out_ready) begin
      out_v <= accept;
      if (accept) begin
        out_b  <= dec_b;
        out_lv <= in_lane_valid;
      end
    end else if (accept) begin
      skid_b  <= dec_b;
      skid_lv <= in_lane_valid;
      skid_v  <= 1'b1;
    end
  end

endmodule
